synch_3_arst: RTL and testbench

- Multi-bit, 3-flop clock-domain-crossing synchronizer with per-bit edge detection.
- Brings quasi-static or slowly changing signals from an arbitrary or asynchronous domain into the `clk` domain, for example audio sample words sampled on an I2S bit clock.
- Also produces single-cycle rising and falling edge strobes per bit.
- Adds an asynchronous active-low reset that forces all stages to a known value.

---
 rtl/synch_3_arst.sv | 44 ++++
 tb/tb_synch_3_arst.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/synch_3_arst.sv
// Three-flop multi-bit synchronizer into the clk domain, with per-bit rise/fall strobes.
// All stages reset asynchronously to RESET_VALUE; bits are independent (no word coherence).
module synch_3_arst #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    generate
        if (WIDTH < 1) begin : g_width_check
            $error("synch_3_arst: WIDTH must be at least 1");
        end
    endgenerate

    // First two stages resolve metastability; none of the stages may be packed into an SRL.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", shreg_extract = "no" *) logic [WIDTH-1:0] s1;
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", shreg_extract = "no" *) logic [WIDTH-1:0] s2;
    (* SHREG_EXTRACT = "NO", shreg_extract = "no" *)                     logic [WIDTH-1:0] s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_VALUE;
            s2 <= RESET_VALUE;
            s3 <= RESET_VALUE;
        end else begin
            s1 <= i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign o = s3;

    // Strobes lead o by one cycle; s2 == s3 during reset keeps them low.
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: tb/tb_synch_3_arst.sv
// Scoreboard bench for synch_3_arst: three instances (32-bit, 1-bit, 16-bit with non-zero reset).
// Expected o/rise/fall per cycle are queued when stimulus is driven and popped at each falling edge.
module tb_synch_3_arst;

    typedef struct {
        logic [31:0] o;
        logic [31:0] r;
        logic [31:0] f;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32_n, rst1_n, rst16_n;
    logic [31:0] i32, o32, r32, f32;
    logic        i1, o1, r1, f1;
    logic [15:0] i16, o16, r16, f16;

    synch_3_arst #(.WIDTH(32), .RESET_VALUE(32'h0)) u32 (
        .i(i32), .o(o32), .clk(clk), .reset_n(rst32_n), .rise(r32), .fall(f32));

    synch_3_arst #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .i(i1), .o(o1), .clk(clk), .reset_n(rst1_n), .rise(r1), .fall(f1));

    synch_3_arst #(.WIDTH(16), .RESET_VALUE(16'h8000)) u16 (
        .i(i16), .o(o16), .clk(clk), .reset_n(rst16_n), .rise(r16), .fall(f16));

    function automatic void push(input logic [31:0] o, input logic [31:0] r, input logic [31:0] f);
        exp_t e;
        e.o = o;
        e.r = r;
        e.f = f;
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) push(32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (o32 !== e.o) begin n_fail++; $display("FAIL reset_hold_o cyc%0d: got %h want %h", k, o32, e.o); end
            n_checks++;
            if (r32 !== e.r) begin n_fail++; $display("FAIL reset_hold_rise cyc%0d: got %h want %h", k, r32, e.r); end
            n_checks++;
            if (f32 !== e.f) begin n_fail++; $display("FAIL reset_hold_fall cyc%0d: got %h want %h", k, f32, e.f); end
        end
        rst32_n = 1'b1;
        push(32'h0, 32'h0, 32'h0);
        push(32'h0, 32'hDEADBEEF, 32'h0);
        push(32'hDEADBEEF, 32'h0, 32'h0);
        push(32'hDEADBEEF, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (o32 !== e.o) begin n_fail++; $display("FAIL release_o edge%0d: got %h want %h", k + 1, o32, e.o); end
            n_checks++;
            if (r32 !== e.r) begin n_fail++; $display("FAIL release_rise edge%0d: got %h want %h", k + 1, r32, e.r); end
            n_checks++;
            if (f32 !== e.f) begin n_fail++; $display("FAIL release_fall edge%0d: got %h want %h", k + 1, f32, e.f); end
        end
        // Asynchronous assertion away from any clock edge must clear o at once.
        @(posedge clk);
        #2 rst32_n = 1'b0;
        #1;
        n_checks++;
        if (o32 !== 32'h0) begin n_fail++; $display("FAIL async_clear_o: got %h want %h", o32, 32'h0); end
        n_checks++;
        if ((r32 | f32) !== 32'h0) begin n_fail++; $display("FAIL async_clear_strobes: got %h want 0", r32 | f32); end
    endtask

    task automatic check_u1(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: scoreboard empty at cycle %0d", name, k);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if ({31'b0, o1} !== e.o) begin n_fail++; $display("FAIL %s_o cyc%0d: got %b want %b", name, k, o1, e.o[0]); end
                n_checks++;
                if ({31'b0, r1} !== e.r) begin n_fail++; $display("FAIL %s_rise cyc%0d: got %b want %b", name, k, r1, e.r[0]); end
                n_checks++;
                if ({31'b0, f1} !== e.f) begin n_fail++; $display("FAIL %s_fall cyc%0d: got %b want %b", name, k, f1, e.f[0]); end
            end
        end
    endtask

    task automatic test_latency();
        rst1_n = 1'b1;
        i1     = 1'b0;
        push(0, 0, 0);
        push(0, 0, 0);
        check_u1("idle", 2);
        i1 = 1'b1;
        push(0, 0, 0);
        push(0, 1, 0);
        push(1, 0, 0);
        push(1, 0, 0);
        check_u1("latency", 4);
    endtask

    task automatic test_falling();
        i1 = 1'b0;
        push(1, 0, 0);
        push(1, 0, 1);
        push(0, 0, 0);
        push(0, 0, 0);
        check_u1("falling", 4);
    endtask

    task automatic test_async_midflight();
        i1 = 1'b1;
        @(posedge clk);
        #2 rst1_n = 1'b0;
        #1;
        n_checks++;
        if ({o1, r1, f1} !== 3'b000) begin n_fail++; $display("FAIL midflight_clear: got o/r/f %b%b%b want 000", o1, r1, f1); end
        #1 rst1_n = 1'b1;
        // Captured value was discarded: full three-edge latency restarts.
        push(0, 0, 0);
        push(0, 0, 0);
        push(0, 1, 0);
        push(1, 0, 0);
        check_u1("midflight", 4);
    endtask

    task automatic test_back_to_back();
        i1 = 1'b0;
        push(1, 0, 0);
        push(1, 0, 1);
        push(0, 0, 0);
        check_u1("settle", 3);
        push(0, 0, 0);
        push(0, 1, 0);
        push(1, 0, 1);
        push(0, 1, 0);
        push(1, 0, 1);
        push(0, 1, 0);
        push(1, 0, 1);
        push(0, 0, 0);
        i1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check_u1("toggle", 1);
            i1 = (k < 6) ? ~i1 : 1'b0;
        end
    endtask

    task automatic test_short_pulse();
        i1 = 1'b0;
        @(posedge clk);
        #2 i1 = 1'b1;
        #4 i1 = 1'b0;
        for (int k = 0; k < 4; k++) push(0, 0, 0);
        check_u1("short_pulse", 4);
    endtask

    task automatic test_nonzero_reset();
        i16 = 16'h0;
        push(32'h8000, 0, 0);
        push(32'h8000, 0, 0);
        push(32'h8000, 0, 0);
        push(32'h8000, 0, 32'h8000);
        push(0, 0, 0);
        push(0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            if (k == 2) rst16_n = 1'b1;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({16'h0, o16} !== e.o) begin n_fail++; $display("FAIL nzreset_o cyc%0d: got %h want %h", k, o16, e.o[15:0]); end
            n_checks++;
            if ({16'h0, r16} !== e.r) begin n_fail++; $display("FAIL nzreset_rise cyc%0d: got %h want %h", k, r16, e.r[15:0]); end
            n_checks++;
            if ({16'h0, f16} !== e.f) begin n_fail++; $display("FAIL nzreset_fall cyc%0d: got %h want %h", k, f16, e.f[15:0]); end
        end
    endtask

    initial begin
        rst32_n = 1'b0;
        rst1_n  = 1'b0;
        rst16_n = 1'b0;
        i32     = 32'hDEADBEEF;
        i1      = 1'b0;
        i16     = 16'h0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_latency();
        test_falling();
        test_async_midflight();
        test_back_to_back();
        test_short_pulse();
        @(negedge clk);
        test_nonzero_reset();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
